dsky_relay_decoder: RTL and testbench

- DSKY-side receiver for the channel 10 relay-word outputs driven by the A17 input/output-channel module (RLYB01..RLYB11, RYWD12/13/14/16).
- Emulates the latching relay matrix: each valid relay word is debounced for a relay pickup time, then latched into one of 12 row registers.
- Rows are read back for display drive; row 12 (indicator lamps) is also exported directly.
- Sits between the A17 channel 10 outputs and the display/lamp model.

---
 rtl/dsky_pkg.sv | 25 ++
 rtl/relay_row_file.sv | 49 ++++
 rtl/dsky_relay_decoder.sv | 123 ++++++++++++
 tb/tb_dsky_relay_decoder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsky_pkg.sv
// Shared types and constants for the DSKY relay-word receiver.
// Relay words are {address, data}; rows 1..12 are addressable, 12 drives the lamps.
package dsky_pkg;

    localparam int RELAY_ADDR_W = 4;
    localparam int RELAY_DATA_W = 11;
    localparam int LAMP_ROW     = 12;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COMMIT,
        HOLD
    } relay_state_e;

    typedef struct packed {
        logic [RELAY_ADDR_W-1:0] addr;
        logic [RELAY_DATA_W-1:0] data;
    } relay_word_t;

    function automatic logic relay_addr_valid(input logic [RELAY_ADDR_W-1:0] addr);
        return (addr != '0) && (addr <= RELAY_ADDR_W'(LAMP_ROW));
    endfunction

endpackage

// File: rtl/relay_row_file.sv
// Latching relay row storage: one synchronous write port, one combinational
// read port, asynchronous clear. Rows are addressed 1..NROWS.
module relay_row_file
    import dsky_pkg::*;
#(
    parameter int NROWS = 12
) (
    input  logic                    CLOCK,
    input  logic                    rst,
    input  logic                    we,
    input  logic [RELAY_ADDR_W-1:0] wr_addr,
    input  logic [RELAY_DATA_W-1:0] wr_data,
    input  logic [RELAY_ADDR_W-1:0] rd_addr,
    output logic [RELAY_DATA_W-1:0] rd_data
);

    logic [RELAY_DATA_W-1:0] rows_q [NROWS];
    logic [RELAY_DATA_W-1:0] rows_d [NROWS];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = (wr_addr != '0) && (int'(wr_addr) <= NROWS);
    assign rd_ok = (rd_addr != '0) && (int'(rd_addr) <= NROWS);

    always_comb begin
        rows_d = rows_q;
        if (we && wr_ok) begin
            rows_d[RELAY_ADDR_W'(wr_addr - 1'b1)] = wr_data;
        end
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            rows_q <= '{default: '0};
        end else begin
            rows_q <= rows_d;
        end
    end

    // Read sees the pre-write value when reading the row being committed.
    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            rd_data = rows_q[RELAY_ADDR_W'(rd_addr - 1'b1)];
        end
    end

endmodule

// File: rtl/dsky_relay_decoder.sv
// DSKY-side channel 10 relay-word receiver: debounces each relay word for the
// relay pickup time, then latches it into the row file (row 12 also to LAMPS).
module dsky_relay_decoder
    import dsky_pkg::*;
#(
    parameter int PICKUP_CYC = 20,
    parameter int NROWS      = 12
) (
    input  logic                    CLOCK,
    input  logic                    rst,
    input  logic [11:1]             RLYB,
    input  logic [3:0]              RYWD,
    input  logic [3:0]              RDADDR,
    output logic [11:1]             RDDATA,
    output logic [11:1]             LAMPS,
    output logic                    UPDATED,
    output logic [3:0]              UPDROW,
    output logic                    ILLADR,
    output logic                    BUSY
);

    relay_state_e            state_q, state_d;
    relay_word_t             s_q, s_d;
    relay_word_t             w;
    logic [7:0]              cnt_q, cnt_d;
    logic [3:0]              updrow_q, updrow_d;
    logic [RELAY_DATA_W-1:0] lamps_q, lamps_d;
    logic                    wr_en;
    logic                    illadr;
    logic                    w_valid;
    logic                    w_illegal;
    logic                    w_changed;
    logic                    reeval;

    assign w         = {RYWD, RLYB};
    assign w_valid   = relay_addr_valid(w.addr);
    assign w_illegal = (w.addr > RELAY_ADDR_W'(LAMP_ROW));
    assign w_changed = (w != s_q);

    // IDLE always looks at the input; SETTLE and HOLD only when the word moves.
    assign reeval = (state_q == IDLE) ||
                    (((state_q == SETTLE) || (state_q == HOLD)) && w_changed);

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        updrow_d = updrow_q;
        lamps_d  = lamps_q;
        wr_en    = 1'b0;
        illadr   = 1'b0;

        if (reeval) begin
            if (w_valid) begin
                s_d     = w;
                cnt_d   = '0;
                state_d = SETTLE;
            end else begin
                state_d = IDLE;
                if (w_illegal && w_changed) begin
                    illadr = 1'b1;
                    s_d    = w;
                end
            end
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == 8'(PICKUP_CYC - 1)) begin
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                COMMIT: begin
                    wr_en    = 1'b1;
                    updrow_d = s_q.addr;
                    if (s_q.addr == RELAY_ADDR_W'(LAMP_ROW)) begin
                        lamps_d = s_q.data;
                    end
                    state_d = HOLD;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            cnt_q    <= '0;
            updrow_q <= '0;
            lamps_q  <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            updrow_q <= updrow_d;
            lamps_q  <= lamps_d;
        end
    end

    relay_row_file #(
        .NROWS(NROWS)
    ) u_rows (
        .CLOCK  (CLOCK),
        .rst    (rst),
        .we     (wr_en),
        .wr_addr(s_q.addr),
        .wr_data(s_q.data),
        .rd_addr(RDADDR),
        .rd_data(RDDATA)
    );

    assign UPDATED = (state_q == COMMIT);
    assign UPDROW  = (state_q == COMMIT) ? s_q.addr : updrow_q;
    assign BUSY    = (state_q == SETTLE);
    assign ILLADR  = illadr;
    assign LAMPS   = lamps_q;

endmodule

// File: tb/tb_dsky_relay_decoder.sv
// Directed bench for dsky_relay_decoder: commit latency, debounce restart,
// lamp row, illegal addresses and reset during settle.
module tb_dsky_relay_decoder;

    logic        CLOCK = 1'b0;
    logic        rst;
    logic [10:0] RLYB;
    logic [3:0]  RYWD;
    logic [3:0]  RDADDR;
    logic [10:0] RDDATA;
    logic [10:0] LAMPS;
    logic        UPDATED;
    logic [3:0]  UPDROW;
    logic        ILLADR;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    int          upd_count;
    int          first_upd;
    int          ill_count;
    int          busy_cnt;
    logic [3:0]  updrow_at;
    logic [10:0] rd_at;
    logic        bad_seen;
    logic [10:0] bad_val;

    dsky_relay_decoder #(
        .PICKUP_CYC(20),
        .NROWS     (12)
    ) dut (
        .CLOCK  (CLOCK),
        .rst    (rst),
        .RLYB   (RLYB),
        .RYWD   (RYWD),
        .RDADDR (RDADDR),
        .RDDATA (RDDATA),
        .LAMPS  (LAMPS),
        .UPDATED(UPDATED),
        .UPDROW (UPDROW),
        .ILLADR (ILLADR),
        .BUSY   (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic drive(input logic [3:0] a, input logic [10:0] d);
        RYWD = a;
        RLYB = d;
    endtask

    // Cycle 0 is the interval in which the word was driven; samples mid-low-phase.
    task automatic monitor(input int n);
        upd_count = 0;
        first_upd = -1;
        ill_count = 0;
        busy_cnt  = 0;
        bad_seen  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge CLOCK);
            #1;
            if (UPDATED === 1'b1) begin
                upd_count++;
                if (first_upd < 0) begin
                    first_upd = i;
                    updrow_at = UPDROW;
                    rd_at     = RDDATA;
                end
            end
            if (ILLADR === 1'b1) ill_count++;
            if (BUSY === 1'b1) busy_cnt++;
            if (RDDATA === bad_val) bad_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'd0, 11'd0);
        RDADDR = 4'd0;
        bad_val = 11'h7FF;
        #1;
        checks++;
        if ({UPDATED, ILLADR, BUSY, UPDROW, LAMPS} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 0", {UPDATED, ILLADR, BUSY, UPDROW, LAMPS});
        end
        @(negedge CLOCK);
        @(negedge CLOCK);
        rst = 1'b0;
        monitor(100);
        checks++;
        if (upd_count != 0 || ill_count != 0 || busy_cnt != 0) begin
            errors++;
            $display("[TB] FAIL idle_zero_word got upd=%0d ill=%0d busy=%0d want 0 0 0", upd_count, ill_count, busy_cnt);
        end
        for (int a = 0; a < 16; a++) begin
            RDADDR = 4'(a);
            #1;
            checks++;
            if (RDDATA !== 11'd0) begin
                errors++;
                $display("[TB] FAIL reset_row%0d got %h want 000", a, RDDATA);
            end
        end
    endtask

    task automatic test_row11();
        RDADDR = 4'd11;
        bad_val = 11'h7FF;
        @(negedge CLOCK);
        drive(4'b1011, 11'h5A5);
        monitor(25);
        checks++;
        if (first_upd != 21 || upd_count != 1) begin
            errors++;
            $display("[TB] FAIL row11_latency got first=%0d count=%0d want 21 1", first_upd, upd_count);
        end
        checks++;
        if (updrow_at !== 4'd11) begin
            errors++;
            $display("[TB] FAIL row11_updrow got %0d want 11", updrow_at);
        end
        checks++;
        if (rd_at !== 11'h000) begin
            errors++;
            $display("[TB] FAIL row11_read_during_write got %h want 000", rd_at);
        end
        checks++;
        if (busy_cnt != 20) begin
            errors++;
            $display("[TB] FAIL row11_busy_cycles got %0d want 20", busy_cnt);
        end
        checks++;
        if (RDDATA !== 11'h5A5 || UPDROW !== 4'd11) begin
            errors++;
            $display("[TB] FAIL row11_data got %h/%0d want 5a5/11", RDDATA, UPDROW);
        end
        monitor(200);
        checks++;
        if (upd_count != 0) begin
            errors++;
            $display("[TB] FAIL row11_single_commit got %0d want 0", upd_count);
        end
    endtask

    task automatic test_glitch();
        RDADDR = 4'd3;
        bad_val = 11'h123;
        @(negedge CLOCK);
        drive(4'd3, 11'h123);
        monitor(10);
        checks++;
        if (upd_count != 0 || bad_seen) begin
            errors++;
            $display("[TB] FAIL glitch_short got upd=%0d bad=%0d want 0 0", upd_count, bad_seen);
        end
        @(negedge CLOCK);
        drive(4'd3, 11'h124);
        monitor(25);
        checks++;
        if (first_upd != 21 || upd_count != 1 || bad_seen) begin
            errors++;
            $display("[TB] FAIL glitch_restart got first=%0d count=%0d bad=%0d want 21 1 0", first_upd, upd_count, bad_seen);
        end
        checks++;
        if (RDDATA !== 11'h124) begin
            errors++;
            $display("[TB] FAIL glitch_row3 got %h want 124", RDDATA);
        end
    endtask

    task automatic test_lamps();
        RDADDR = 4'd12;
        bad_val = 11'h555;
        @(negedge CLOCK);
        drive(4'b1100, 11'h7FF);
        monitor(25);
        checks++;
        if (first_upd != 21 || LAMPS !== 11'h7FF || RDDATA !== 11'h7FF) begin
            errors++;
            $display("[TB] FAIL lamps_commit got first=%0d lamps=%h row=%h want 21 7ff 7ff", first_upd, LAMPS, RDDATA);
        end
        @(negedge CLOCK);
        drive(4'd0, 11'd0);
        monitor(50);
        checks++;
        if (LAMPS !== 11'h7FF || upd_count != 0 || busy_cnt != 0) begin
            errors++;
            $display("[TB] FAIL lamps_hold got lamps=%h upd=%0d busy=%0d want 7ff 0 0", LAMPS, upd_count, busy_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  addrs [4];
        logic [10:0] exp   [4];
        addrs = '{4'd3, 4'd11, 4'd12, 4'd1};
        exp   = '{11'h124, 11'h5A5, 11'h7FF, 11'h000};
        RDADDR = 4'd1;
        bad_val = 11'h555;
        @(negedge CLOCK);
        drive(4'b1110, 11'h0AA);
        monitor(30);
        checks++;
        if (ill_count != 1 || upd_count != 0 || busy_cnt != 0) begin
            errors++;
            $display("[TB] FAIL illegal_pulse got ill=%0d upd=%0d busy=%0d want 1 0 0", ill_count, upd_count, busy_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            RDADDR = addrs[i];
            #1;
            checks++;
            if (RDDATA !== exp[i]) begin
                errors++;
                $display("[TB] FAIL illegal_rows addr=%0d got %h want %h", addrs[i], RDDATA, exp[i]);
            end
        end
        for (int a = 13; a < 17; a++) begin
            RDADDR = 4'(a);
            #1;
            checks++;
            if (RDDATA !== 11'd0) begin
                errors++;
                $display("[TB] FAIL out_of_range_read addr=%0d got %h want 000", RDADDR, RDDATA);
            end
        end
        RDADDR = 4'd1;
        @(negedge CLOCK);
        drive(4'd1, 11'h3C3);
        monitor(25);
        checks++;
        if (first_upd != 21 || updrow_at !== 4'd1 || RDDATA !== 11'h3C3 || ill_count != 0) begin
            errors++;
            $display("[TB] FAIL illegal_then_row1 got first=%0d row=%0d data=%h ill=%0d want 21 1 3c3 0", first_upd, updrow_at, RDDATA, ill_count);
        end
    endtask

    task automatic test_reset_mid_settle();
        RDADDR = 4'd5;
        bad_val = 11'h555;
        @(negedge CLOCK);
        drive(4'd5, 11'h055);
        monitor(15);
        checks++;
        if (upd_count != 0 || busy_cnt != 14) begin
            errors++;
            $display("[TB] FAIL settle_before_reset got upd=%0d busy=%0d want 0 14", upd_count, busy_cnt);
        end
        @(negedge CLOCK);
        rst = 1'b1;
        #1;
        for (int a = 1; a <= 12; a++) begin
            RDADDR = 4'(a);
            #1;
            checks++;
            if (RDDATA !== 11'd0) begin
                errors++;
                $display("[TB] FAIL reset_clear_row%0d got %h want 000", a, RDDATA);
            end
        end
        checks++;
        if ({UPDATED, BUSY, LAMPS, UPDROW} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_clear_outputs got %h want 0", {UPDATED, BUSY, LAMPS, UPDROW});
        end
        RDADDR = 4'd5;
        @(negedge CLOCK);
        rst = 1'b0;
        monitor(25);
        checks++;
        if (first_upd != 21 || upd_count != 1 || RDDATA !== 11'h055) begin
            errors++;
            $display("[TB] FAIL reset_recommit got first=%0d count=%0d data=%h want 21 1 055", first_upd, upd_count, RDDATA);
        end
    endtask

    task automatic test_back_to_back();
        RDADDR = 4'd5;
        bad_val = 11'h555;
        @(negedge CLOCK);
        drive(4'd0, 11'd0);
        monitor(3);
        @(negedge CLOCK);
        drive(4'd5, 11'h055);
        monitor(25);
        checks++;
        if (first_upd != 21 || upd_count != 1) begin
            errors++;
            $display("[TB] FAIL represent_same_word got first=%0d count=%0d want 21 1", first_upd, upd_count);
        end
        @(negedge CLOCK);
        drive(4'd6, 11'h055);
        RDADDR = 4'd6;
        monitor(25);
        checks++;
        if (first_upd != 21 || updrow_at !== 4'd6 || RDDATA !== 11'h055) begin
            errors++;
            $display("[TB] FAIL same_data_new_row got first=%0d row=%0d data=%h want 21 6 055", first_upd, updrow_at, RDDATA);
        end
    endtask

    initial begin
        test_reset();
        test_row11();
        test_glitch();
        test_lamps();
        test_illegal();
        test_reset_mid_settle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
